// File: rtl/mb_valid_pkg.sv
// Shared definitions for the mainband valid-lane VALTRAIN generator and detector.
//   VALTRAIN_8B     : one 8-UI pattern iteration, bit 0 is the first UI
//   VALTRAIN_32B    : one 32-bit lane word carrying ITERS_PER_WORD iterations
//   vld_gen_state_t : generator burst sequencing states
package mb_valid_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ITERS_PER_WORD = 4;
    localparam int unsigned INJ_WORD_W     = 12;

    localparam logic [7:0]        VALTRAIN_8B  = 8'b1111_0000;
    localparam logic [WORD_W-1:0] VALTRAIN_32B = {4{VALTRAIN_8B}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } vld_gen_state_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vld_word_counter.sv
// Loadable down-counter with enable and a terminal flag.
//   i_clk      : clock
//   i_rst      : synchronous, active-high reset (count -> 0)
//   i_load     : load i_load_val (has priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one; holds at zero
//   o_last_c   : combinational flag, count == 1 (last word of the run)
module vld_word_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_last_c
);

    logic [W-1:0] count_q;

    // Count register; never wraps below zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= i_load_val;
        end else if (i_en && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign o_last_c = (count_q == W'(1));

endmodule

// File: rtl/valid_pattern_generator.sv
// Transmit-side VALTRAIN source for the mainband valid lane.
// Sends one burst per start request: PRE_IDLE_WORDS all-zero words, then the
// repeating 8'b11110000 pattern (4 iterations per 32-bit word) for either
// ITER_128_COUNT or ITER_CONS_COUNT iterations, then a one-cycle done pulse.
// Optional feature macro: VALID_ERR_INJECT_EN (corrupts one chosen pattern word).
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : burst request (IDLE only); i_mode_128 selects burst length
//   i_abort        : stop the burst, return to IDLE without o_done
//   i_ready        : serializer accepts o_tvld_l this cycle
//   i_inj_en/i_inj_word/i_inj_mask : error injection (VALID_ERR_INJECT_EN only)
//   o_tvld_l       : valid-lane word, bit 0 = first UI
//   o_word_valid   : o_tvld_l is meaningful
//   o_busy         : burst in progress
//   o_done         : one-cycle pulse after the last pattern word is accepted
module valid_pattern_generator
    import mb_valid_pkg::*;
#(
    parameter int unsigned ITER_128_COUNT  = 128,
    parameter int unsigned ITER_CONS_COUNT = 16,
    parameter int unsigned PRE_IDLE_WORDS  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_mode_128,
    input  logic                  i_abort,
    input  logic                  i_ready,
`ifdef VALID_ERR_INJECT_EN
    input  logic                  i_inj_en,
    input  logic [INJ_WORD_W-1:0] i_inj_word,
    input  logic [WORD_W-1:0]     i_inj_mask,
`endif
    output logic [WORD_W-1:0]     o_tvld_l,
    output logic                  o_word_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned WORDS_128  = ITER_128_COUNT / ITERS_PER_WORD;
    localparam int unsigned WORDS_CONS = ITER_CONS_COUNT / ITERS_PER_WORD;
    localparam int unsigned MAX_WORDS  = (WORDS_128 > WORDS_CONS) ? WORDS_128 : WORDS_CONS;
    localparam int unsigned CNT_W      = cnt_width(MAX_WORDS);
    localparam int unsigned PRE_W      = cnt_width(PRE_IDLE_WORDS);
    localparam bit          HAS_PRE    = (PRE_IDLE_WORDS != 0);

    vld_gen_state_t    state_q;
    vld_gen_state_t    state_d;

    logic              take_start;
    logic              cnt_load;
    logic [PRE_W-1:0]  pre_load_val;
    logic [CNT_W-1:0]  send_load_val;
    logic              pre_en;
    logic              send_en;
    logic              pre_last;
    logic              send_last;

    logic [WORD_W-1:0] pattern_word;
    logic [WORD_W-1:0] tvld_d;
    logic              word_valid_d;
    logic              busy_d;
    logic              done_d;

    // A simultaneous abort cancels the start request.
    assign take_start = i_start && !i_abort;

    // Both counters reload in IDLE: burst length on a start, zero otherwise.
    assign cnt_load      = (state_q == IDLE);
    assign pre_load_val  = take_start ? PRE_W'(PRE_IDLE_WORDS) : '0;
    assign send_load_val = !take_start ? '0 :
                           (i_mode_128 ? CNT_W'(WORDS_128) : CNT_W'(WORDS_CONS));
    assign pre_en        = (state_q == PRE)  && i_ready;
    assign send_en       = (state_q == SEND) && i_ready;

    vld_word_counter #(.W(PRE_W)) u_pre_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (cnt_load),
        .i_load_val (pre_load_val),
        .i_en       (pre_en),
        .o_last_c   (pre_last)
    );

    vld_word_counter #(.W(CNT_W)) u_send_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (cnt_load),
        .i_load_val (send_load_val),
        .i_en       (send_en),
        .o_last_c   (send_last)
    );

`ifdef VALID_ERR_INJECT_EN
    logic [INJ_WORD_W-1:0] idx_q;
    logic [INJ_WORD_W-1:0] idx_d;

    // Index of the pattern word presented next cycle; advances on each accept.
    always_comb begin
        idx_d = '0;
        if (state_q == SEND) begin
            idx_d = i_ready ? (idx_q + INJ_WORD_W'(1)) : idx_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign pattern_word = (i_inj_en && (idx_d == i_inj_word)) ?
                          (VALTRAIN_32B ^ i_inj_mask) : VALTRAIN_32B;
`else
    assign pattern_word = VALTRAIN_32B;
`endif

    // Next-state and next-output logic; outputs are registered from state_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_start) begin
                    state_d = HAS_PRE ? PRE : SEND;
                end
            end
            PRE: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_ready && pre_last) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_ready && send_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        word_valid_d = (state_d == PRE) || (state_d == SEND);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        tvld_d       = (state_d == SEND) ? pattern_word : '0;
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            o_tvld_l     <= '0;
            o_word_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_tvld_l     <= tvld_d;
            o_word_valid <= word_valid_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
        end
    end

endmodule

// File: tb/tb_valid_pattern_generator.sv
// Scoreboard bench for valid_pattern_generator: the driver pushes the expected
// accepted-word stream of each burst, a negedge monitor pops and compares.
module tb_valid_pattern_generator;

    localparam int unsigned PRE   = 2;
    localparam int unsigned N128  = 128;
    localparam int unsigned NCONS = 16;
    localparam logic [31:0] PAT   = 32'hF0F0_F0F0;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_mode_128 = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] o_tvld_l;
    logic        o_word_valid;
    logic        o_busy;
    logic        o_done;
`ifdef VALID_ERR_INJECT_EN
    logic        i_inj_en = 1'b0;
    logic [11:0] i_inj_word = 12'd0;
    logic [31:0] i_inj_mask = 32'd0;
`endif

    valid_pattern_generator #(
        .ITER_128_COUNT  (N128),
        .ITER_CONS_COUNT (NCONS),
        .PRE_IDLE_WORDS  (PRE)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_mode_128   (i_mode_128),
        .i_abort      (i_abort),
        .i_ready      (i_ready),
`ifdef VALID_ERR_INJECT_EN
        .i_inj_en     (i_inj_en),
        .i_inj_word   (i_inj_word),
        .i_inj_mask   (i_inj_mask),
`endif
        .o_tvld_l     (o_tvld_l),
        .o_word_valid (o_word_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          is_done;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          rmode  = 0;
    int          phase  = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; drive i_ready according to the current pattern mode.
    task automatic step();
        @(posedge i_clk);
        #1;
        case (rmode)
            0: i_ready = 1'b1;
            1: begin
                i_ready = (phase == 0) || (phase == 3);
                phase   = (phase + 1) % 4;
            end
            2: i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b0;
        endcase
    endtask

    function automatic logic [31:0] exp_word(input int idx);
        logic [31:0] w;
        w = PAT;
`ifdef VALID_ERR_INJECT_EN
        if (i_inj_en && (idx == int'(i_inj_word))) w = PAT ^ i_inj_mask;
`endif
        return w;
    endfunction

    // Reference stream: PRE zero words, count/4 pattern words, done marker.
    // stop_after >= 0 truncates after that many pattern words (no done).
    task automatic push_burst(input bit mode, input int stop_after);
        int   n;
        exp_t e;
        n = mode ? int'(N128 / 4) : int'(NCONS / 4);
        for (int i = 0; i < int'(PRE); i++) begin
            e.is_done = 1'b0; e.data = '0; q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (stop_after >= 0 && i >= stop_after) return;
            e.is_done = 1'b0; e.data = exp_word(i); q.push_back(e);
        end
        e.is_done = 1'b1; e.data = '0; q.push_back(e);
    endtask

    // Issue one burst and follow it to IDLE; optionally poke i_start mid-burst.
    task automatic run_burst(input bit mode, input int busy_start_at);
        int c;
        int busy_cnt;
        int done_at;
        int exp_len;
        push_burst(mode, -1);
        i_start = 1'b1; i_mode_128 = mode;
        step();
        i_start = 1'b0;
        c = 1; busy_cnt = 0; done_at = 0;
        while (c < 3000) begin
            if (o_busy) busy_cnt++;
            if (o_done && done_at == 0) done_at = c;
            if (!o_busy) break;
            if (c == busy_start_at) begin
                i_start = 1'b1; i_mode_128 = ~mode;
            end
            step();
            i_start = 1'b0;
            c++;
        end
        if (c >= 3000) begin
            checks++; errors++;
            $display("FAIL burst_timeout: busy still %b after %0d cycles", o_busy, c);
        end
        if (rmode == 0) begin
            exp_len = int'(PRE) + (mode ? int'(N128 / 4) : int'(NCONS / 4)) + 1;
            chk("done_cycle", 32'(done_at), 32'(exp_len));
            chk("busy_cycles", 32'(busy_cnt), 32'(exp_len));
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    // Monitor: compares every accepted word and done pulse against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (hold_pend && o_word_valid) chk("hold_stable", o_tvld_l, held);
            hold_pend = o_word_valid && !i_ready;
            held      = o_tvld_l;
            if (o_word_valid && i_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %h expected none", o_tvld_l);
                end else begin
                    e = q.pop_front();
                    chk("word_not_done", 32'(e.is_done), 32'd0);
                    chk("word_data", o_tvld_l, e.data);
                end
            end
            if (o_done) begin
                chk("done_quiet", {o_tvld_l[31:1], o_tvld_l[0] | o_word_valid}, 32'd0);
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got o_done=1 expected none");
                end else begin
                    e = q.pop_front();
                    chk("done_order", 32'(e.is_done), 32'd1);
                end
            end
        end
    end

    initial begin
        // Reset state
        rmode = 0;
        repeat (3) step();
        chk("rst_tvld", o_tvld_l, 32'd0);
        chk("rst_valid", 32'(o_word_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        step();

        // 128-iteration and consecutive bursts, ready held high
        run_burst(1'b1, 0);
        step();
        run_burst(1'b0, 0);
        step();

        // Backpressure 1,0,0,1
        rmode = 1; phase = 0;
        run_burst(1'b1, 0);
        rmode = 0;
        step();

        // Start while busy is ignored (length and timing unchanged)
        run_burst(1'b1, 10);
        step();

        // Abort after 10 accepted pattern words, restart one cycle later
        push_burst(1'b1, 10);
        i_start = 1'b1; i_mode_128 = 1'b1;
        step();
        i_start = 1'b0;
        repeat (PRE + 10) step();
        i_abort = 1'b1; i_ready = 1'b0;
        step();
        i_abort = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_tvld", o_tvld_l, 32'd0);
        chk("abort_valid", 32'(o_word_valid), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_queue", 32'(q.size()), 32'd0);
        run_burst(1'b0, 0);
        step();

        // Start together with abort stays idle
        i_start = 1'b1; i_abort = 1'b1;
        step();
        i_start = 1'b0; i_abort = 1'b0;
        chk("start_abort_busy", 32'(o_busy), 32'd0);
        step();

        // Reset mid-SEND with random ready
        rmode = 2;
        push_burst(1'b1, -1);
        i_start = 1'b1; i_mode_128 = 1'b1;
        step();
        i_start = 1'b0;
        repeat (PRE + 8) step();
        i_rst = 1'b1;
        step();
        q.delete();
        chk("mid_rst_tvld", o_tvld_l, 32'd0);
        chk("mid_rst_valid", 32'(o_word_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        step();

`ifdef VALID_ERR_INJECT_EN
        // Corrupt pattern word 5
        rmode = 0;
        i_inj_en = 1'b1; i_inj_word = 12'd5; i_inj_mask = 32'h0000_0003;
        run_burst(1'b1, 0);
        i_inj_en = 1'b0;
        step();
`endif

        // Randomised bursts
        for (int k = 0; k < 8; k++) begin
            rmode = $urandom_range(0, 2);
            phase = 0;
            run_burst(1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) step();
        end

        rmode = 0;
        repeat (4) step();
        chk("final_queue", 32'(q.size()), 32'd0);
        chk("final_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
